video_timing_gen: RTL and testbench

Synthesizable video source: generates DE/HSYNC/VSYNC timing plus a selectable 24-bit RGB test pattern on one pixel clock. It is the transmit-side counterpart of the file-based HDMI input model. It drives the `vp` video-processing block directly on hardware and in simulation without stimulus files. Outputs are registered and match the `vp` input port set.

---
 rtl/vtg_pkg.sv | 44 ++++
 rtl/vtg_pattern.sv | 29 ++
 rtl/video_timing_gen.sv | 175 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vtg_pkg.sv
// vtg_pkg: shared types and constants for the video timing generator.
//   pattern_e : test pattern selector encoding
//   state_e   : timing FSM state encoding
//   BAR_*     : colour-bar palette, plus bar_colour() lookup by bar index
package vtg_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vtg_pattern.sv
// vtg_pattern: combinational test-pattern pixel generator.
//   pat_i       : selected pattern
//   x_i, y_i    : pixel coordinates (low 8 bits of the counters)
//   bar_idx_i   : colour-bar index from the bar sub-counter
//   frame_off_i : horizontal scroll offset added to gradient red
//   pixel_o     : 24-bit {R,G,B}
module vtg_pattern
  import vtg_pkg::*;
(
  input  pattern_e    pat_i,
  input  logic [7:0]  x_i,
  input  logic [7:0]  y_i,
  input  logic [2:0]  bar_idx_i,
  input  logic [7:0]  frame_off_i,
  output logic [23:0] pixel_o
);

  always_comb begin
    pixel_o = 24'h000000;
    case (pat_i)
      PAT_SOLID: pixel_o = BAR_WHITE;
      PAT_BARS:  pixel_o = bar_colour(bar_idx_i);
      PAT_GRAD:  pixel_o = {x_i + frame_off_i, y_i, x_i + y_i};
      PAT_CHECK: pixel_o = (x_i[3] ^ y_i[3]) ? BAR_WHITE : BAR_BLACK;
      default:   pixel_o = 24'h000000;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: DE/HSYNC/VSYNC timing generator with selectable RGB
// test pattern. All outputs are registered and lag the counters by one clock.
//   clk, rst_n       : pixel clock, synchronous active-low reset
//   en               : run request (a started frame always completes)
//   pattern_sel      : 0 solid, 1 bars, 2 gradient, 3 checker
//   de_out, h_sync_out, v_sync_out, pixel_out : video outputs
//   busy             : FSM not idle
// Optional macro VTG_FRAME_CNT_EN adds frame_cnt[15:0] and scrolls the
// gradient horizontally by frame_cnt[7:0].
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE = 64,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 8,
  parameter int H_BP     = 4,
  parameter int V_ACTIVE = 48,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 2,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  output logic        de_out,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic [23:0] pixel_out,
  output logic        busy
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  // state    | meaning
  // ST_IDLE  | counters held at (0,0), outputs at reset values
  // ST_RUN   | counters advance, frames repeat while en=1
  // ST_DRAIN | en dropped: finish current frame, then decide at the wrap

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = $clog2(BAR_W + 1);

  state_e          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [BW-1:0]   bar_px_q, bar_px_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  pattern_e        pat_q, pat_d;
  logic            de_q, de_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic [23:0]     pix_q, pix_d;
  logic [23:0]     pat_pix;
  logic [7:0]      frame_off;
  logic            run, h_last, frame_wrap;

`ifdef VTG_FRAME_CNT_EN
  logic [15:0]     frame_q, frame_d;
  assign frame_off = frame_q[7:0];
  assign frame_cnt = frame_q;
`else
  assign frame_off = 8'd0;
`endif

  assign run        = (state_q != ST_IDLE);
  assign h_last     = (int'(h_q) == H_TOTAL - 1);
  assign frame_wrap = h_last && (int'(v_q) == V_TOTAL - 1);

  vtg_pattern u_pattern (
    .pat_i       (pat_q),
    .x_i         (8'(h_q)),
    .y_i         (8'(v_q)),
    .bar_idx_i   (bar_idx_q),
    .frame_off_i (frame_off),
    .pixel_o     (pat_pix)
  );

  always_comb begin
    state_d   = state_q;
    h_d       = '0;
    v_d       = '0;
    bar_px_d  = '0;
    bar_idx_d = '0;
    pat_d     = pat_q;
    de_d      = 1'b0;
    hs_d      = ~SYNC_POL;
    vs_d      = ~SYNC_POL;
    pix_d     = 24'h000000;
`ifdef VTG_FRAME_CNT_EN
    frame_d   = frame_q;
`endif

    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      // a wrap coinciding with en falling goes straight to IDLE
      ST_RUN:   if (!en) state_d = frame_wrap ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (frame_wrap) state_d = en ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if ((!run && en) || (run && frame_wrap)) pat_d = pattern_e'(pattern_sel);

    if (run) begin
      h_d = h_last ? '0 : h_q + 1'b1;
      v_d = v_q;
      if (h_last) v_d = (int'(v_q) == V_TOTAL - 1) ? '0 : v_q + 1'b1;

      // bar index tracks h_cnt by counting bar widths instead of dividing
      if (!h_last) begin
        if (int'(bar_px_q) == BAR_W - 1) begin
          bar_idx_d = bar_idx_q + 1'b1;
        end else begin
          bar_px_d  = bar_px_q + 1'b1;
          bar_idx_d = bar_idx_q;
        end
      end

      de_d = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
      if (int'(h_q) >= H_ACTIVE + H_FP && int'(h_q) < H_ACTIVE + H_FP + H_SYNC)
        hs_d = SYNC_POL;
      if (int'(v_q) >= V_ACTIVE + V_FP && int'(v_q) < V_ACTIVE + V_FP + V_SYNC)
        vs_d = SYNC_POL;
      if (de_d) pix_d = pat_pix;
`ifdef VTG_FRAME_CNT_EN
      if (frame_wrap) frame_d = frame_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      v_q       <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      pat_q     <= PAT_SOLID;
      de_q      <= 1'b0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      pix_q     <= 24'h000000;
`ifdef VTG_FRAME_CNT_EN
      frame_q   <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      pix_q     <= pix_d;
`ifdef VTG_FRAME_CNT_EN
      frame_q   <= frame_d;
`endif
    end
  end

  assign de_out     = de_q;
  assign h_sync_out = hs_q;
  assign v_sync_out = vs_q;
  assign pixel_out  = pix_q;
  assign busy       = run;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed self-checking bench for video_timing_gen
// with default parameters. Four frames are logged (bars, checker, solid,
// gradient) and checked against a vector table, followed by hand-written
// sequences for drain, wrap/en-fall, restart and mid-line reset.
module tb_video_timing_gen;

  localparam int H_TOT = 80;
  localparam int FRAME = 4320;
  localparam int NFR   = 4;
`ifdef VTG_FRAME_CNT_EN
  localparam int FOFF  = 3;
`else
  localparam int FOFF  = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        de_out, h_sync_out, v_sync_out, busy;
  logic [23:0] pixel_out;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  video_timing_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pattern_sel (pattern_sel),
    .de_out      (de_out),
    .h_sync_out  (h_sync_out),
    .v_sync_out  (v_sync_out),
    .pixel_out   (pixel_out),
    .busy        (busy)
`ifdef VTG_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic        de_log  [NFR*FRAME];
  logic        hs_log  [NFR*FRAME];
  logic        vs_log  [NFR*FRAME];
  logic        bsy_log [NFR*FRAME];
  logic [23:0] pix_log [NFR*FRAME];

  typedef struct {
    int          fr;
    int          x;
    int          y;
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] pix;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int fr, int x, int y, logic de, logic hs, logic vs,
                              logic [23:0] pix);
    vec_t v;
    v.fr = fr; v.x = x; v.y = y; v.de = de; v.hs = hs; v.vs = vs; v.pix = pix;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int n, dcnt, hcnt, vcnt, bcnt, idx;

    // frame 0 bars, frame 1 checker, frame 2 solid, frame 3 gradient
    vq.push_back(mk(0,  0,  0, 1, 0, 0, 24'hFFFFFF));
    vq.push_back(mk(0,  7,  0, 1, 0, 0, 24'hFFFFFF));
    vq.push_back(mk(0,  8,  0, 1, 0, 0, 24'hFFFF00));
    vq.push_back(mk(0, 15,  3, 1, 0, 0, 24'hFFFF00));
    vq.push_back(mk(0, 30, 20, 1, 0, 0, 24'h00FF00));
    vq.push_back(mk(0, 40,  1, 1, 0, 0, 24'hFF0000));
    vq.push_back(mk(0, 56, 10, 1, 0, 0, 24'h000000));
    vq.push_back(mk(0, 63, 47, 1, 0, 0, 24'h000000));
    vq.push_back(mk(0, 64,  0, 0, 0, 0, 24'h000000));
    vq.push_back(mk(0, 67,  0, 0, 0, 0, 24'h000000));
    vq.push_back(mk(0, 68,  0, 0, 1, 0, 24'h000000));
    vq.push_back(mk(0, 75,  5, 0, 1, 0, 24'h000000));
    vq.push_back(mk(0, 76,  5, 0, 0, 0, 24'h000000));
    vq.push_back(mk(0,  0, 48, 0, 0, 0, 24'h000000));
    vq.push_back(mk(0,  0, 49, 0, 0, 0, 24'h000000));
    vq.push_back(mk(0,  0, 50, 0, 0, 1, 24'h000000));
    vq.push_back(mk(0, 70, 51, 0, 1, 1, 24'h000000));
    vq.push_back(mk(0, 79, 51, 0, 0, 1, 24'h000000));
    vq.push_back(mk(0,  0, 52, 0, 0, 0, 24'h000000));
    vq.push_back(mk(0, 79, 53, 0, 0, 0, 24'h000000));
    vq.push_back(mk(1,  0,  0, 1, 0, 0, 24'h000000));
    vq.push_back(mk(1,  8,  0, 1, 0, 0, 24'hFFFFFF));
    vq.push_back(mk(1,  8,  8, 1, 0, 0, 24'h000000));
    vq.push_back(mk(1,  0,  8, 1, 0, 0, 24'hFFFFFF));
    vq.push_back(mk(1, 20, 30, 1, 0, 0, 24'hFFFFFF));
    vq.push_back(mk(2,  5,  5, 1, 0, 0, 24'hFFFFFF));
    vq.push_back(mk(2, 64,  5, 0, 0, 0, 24'h000000));
    vq.push_back(mk(3, 10,  5, 1, 0, 0, {8'(10 + FOFF), 8'h05, 8'h0F}));
    vq.push_back(mk(3, 63, 47, 1, 0, 0, {8'(63 + FOFF), 8'h2F, 8'h6E}));
    vq.push_back(mk(3, 64, 47, 0, 0, 0, 24'h000000));

    // reset
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst de", de_out, 1'b0);
    chk("rst hs", h_sync_out, 1'b0);
    chk("rst vs", v_sync_out, 1'b0);
    chk("rst pix", pixel_out, 24'h0);
    chk("rst busy", busy, 1'b0);
`ifdef VTG_FRAME_CNT_EN
    chk("rst frame_cnt", frame_cnt, 16'd0);
`endif
    rst_n = 1'b1;
    tick();
    chk("idle de", de_out, 1'b0);
    chk("idle busy", busy, 1'b0);

    // start-up: E0 sets busy, E1 gives first DE
    en = 1'b1;
    pattern_sel = 2'd1;
    tick();
    chk("E0 busy", busy, 1'b1);
    chk("E0 de", de_out, 1'b0);

    for (int k = 0; k < NFR*FRAME; k++) begin
      if (k == 2000)             pattern_sel = 2'd3;
      if (k == FRAME + 2000)     pattern_sel = 2'd0;
      if (k == 2*FRAME + 2000)   pattern_sel = 2'd2;
      tick();
      de_log[k]  = de_out;
      hs_log[k]  = h_sync_out;
      vs_log[k]  = v_sync_out;
      bsy_log[k] = busy;
      pix_log[k] = pixel_out;
    end

    foreach (vq[i]) begin
      idx = vq[i].fr*FRAME + vq[i].y*H_TOT + vq[i].x;
      chk($sformatf("vec%0d de f%0d (%0d,%0d)", i, vq[i].fr, vq[i].x, vq[i].y),
          de_log[idx], vq[i].de);
      chk($sformatf("vec%0d hs f%0d (%0d,%0d)", i, vq[i].fr, vq[i].x, vq[i].y),
          hs_log[idx], vq[i].hs);
      chk($sformatf("vec%0d vs f%0d (%0d,%0d)", i, vq[i].fr, vq[i].x, vq[i].y),
          vs_log[idx], vq[i].vs);
      chk($sformatf("vec%0d pix f%0d (%0d,%0d)", i, vq[i].fr, vq[i].x, vq[i].y),
          pix_log[idx], vq[i].pix);
    end

    dcnt = 0; hcnt = 0; vcnt = 0; bcnt = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (de_log[k]) dcnt++;
      if (hs_log[k]) hcnt++;
      if (vs_log[k]) vcnt++;
    end
    for (int k = 0; k < NFR*FRAME; k++) if (bsy_log[k]) bcnt++;
    chk("frame de count", dcnt, 64*48);
    chk("frame hs count", hcnt, 8*54);
    chk("frame vs count", vcnt, 2*80);
    chk("busy all frames", bcnt, NFR*FRAME);
    dcnt = 0;
    for (int x = 0; x < H_TOT; x++) if (de_log[20*H_TOT + x]) dcnt++;
    chk("line20 de count", dcnt, 64);
    dcnt = 0;
    for (int k = 0; k < FRAME; k++) if (de_log[FRAME + k] && !pix_log[FRAME + k][0]) dcnt++;
    chk("checker black count", dcnt, 64*48/2);
`ifdef VTG_FRAME_CNT_EN
    chk("frame_cnt after 4", frame_cnt, 16'd4);
`endif

    // drop en at line 20: frame must finish all 54 lines
    for (int k = 0; k < 20*H_TOT; k++) tick();
    en = 1'b0;
    n = 0; dcnt = 0;
    while (busy && n < 6000) begin
      tick();
      n++;
      if (de_out) dcnt++;
    end
    chk("drain clocks", n, 2720);
    chk("drain de count", dcnt, 28*64);
    tick();
    chk("post-drain busy", busy, 1'b0);
    chk("post-drain de", de_out, 1'b0);
    chk("post-drain hs", h_sync_out, 1'b0);
    chk("post-drain vs", v_sync_out, 1'b0);
    chk("post-drain pix", pixel_out, 24'h0);

    // restart from (0,0)
    en = 1'b1;
    pattern_sel = 2'd1;
    tick();
    chk("restart E0 busy", busy, 1'b1);
    chk("restart E0 de", de_out, 1'b0);
    tick();
    chk("restart E1 de", de_out, 1'b1);
    chk("restart E1 pix", pixel_out, 24'hFFFFFF);
    chk("restart E1 hs", h_sync_out, 1'b0);

    // en falls exactly on the wrap edge: straight to IDLE
    for (int k = 0; k < FRAME - 2; k++) tick();
    en = 1'b0;
    tick();
    chk("wrap+en fall busy", busy, 1'b0);
    chk("wrap+en fall de", de_out, 1'b0);
    tick();
    chk("wrap+en fall idle pix", pixel_out, 24'h0);
    chk("wrap+en fall idle busy", busy, 1'b0);

    // reset mid-line while hsync is asserted
    en = 1'b1;
    pattern_sel = 2'd0;
    tick();
    for (int k = 0; k < 61; k++) tick();
    chk("pre-rst de", de_out, 1'b1);
    chk("pre-rst pix", pixel_out, 24'hFFFFFF);
    for (int k = 0; k < 10; k++) tick();
    chk("pre-rst hs", h_sync_out, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("mid rst de", de_out, 1'b0);
    chk("mid rst hs", h_sync_out, 1'b0);
    chk("mid rst vs", v_sync_out, 1'b0);
    chk("mid rst busy", busy, 1'b0);
    chk("mid rst pix", pixel_out, 24'h0);
    rst_n = 1'b1;
    en = 1'b0;
    tick();
    chk("after rst busy", busy, 1'b0);
    chk("after rst de", de_out, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
